// File: rtl/add_sub_pipe.sv
// Two-stage pipelined add/sub/accumulate unit with carry, overflow and zero flags.
// Stage A holds the operand beat; stage B holds the registered result and flags.
module add_sub_pipe #(
   parameter int WIDTH    = 8,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic             sign,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] z,
   output logic             carry,
   output logic             ovf,
   output logic             zero
);

   // Handshake: a beat moves across a boundary on the edge where valid && ready;
   // valid and payload hold until that edge, so beats are never dropped or duplicated.

   logic             r_a_valid;
   logic [1:0]       r_a_op;
   logic             r_a_sign;
   logic [WIDTH-1:0] r_a_x;
   logic [WIDTH-1:0] r_a_y;
   logic [WIDTH-1:0] r_acc;

   logic             r_b_valid;
   logic [WIDTH-1:0] r_z;
   logic             r_carry;
   logic             r_ovf;
   logic             r_zero;

   logic             w_b_ready;
   logic             w_a_ready;
   logic             w_a_xfer;
   logic             w_in_xfer;
   logic             w_is_acc;
   logic             w_is_sub;
   logic [WIDTH-1:0] w_left;
   logic [WIDTH-1:0] w_right;
   logic [WIDTH:0]   w_sum;
   logic             w_carry;
   logic             w_sovf;
   logic             w_ovf;
   logic [WIDTH-1:0] w_sat_val;
   logic [WIDTH-1:0] w_z;

   assign w_b_ready = !r_b_valid || out_ready;
   assign w_a_ready = !r_a_valid || w_b_ready;
   assign w_a_xfer  = r_a_valid && w_b_ready;
   assign w_in_xfer = in_valid && w_a_ready;
   assign w_is_acc  = r_a_op[1];
   assign w_is_sub  = r_a_op[0];

   always_comb begin
      w_left    = r_a_x;
      w_right   = r_a_y;
      w_sum     = '0;
      w_carry   = 1'b0;
      w_sovf    = 1'b0;
      w_ovf     = 1'b0;
      w_sat_val = '0;
      w_z       = '0;
      // A clear coinciding with an accumulate transfer wins: the op sees acc as zero.
      if (w_is_acc) begin
         w_left  = acc_clr ? '0 : r_acc;
         w_right = r_a_x;
      end
      if (w_is_sub) begin
         w_sum = {1'b0, w_left} - {1'b0, w_right};
      end else begin
         w_sum = {1'b0, w_left} + {1'b0, w_right};
      end
      w_carry = w_sum[WIDTH];
      w_sovf  = (w_sum[WIDTH-1] != w_left[WIDTH-1]) &&
                (w_is_sub ? (w_left[WIDTH-1] != w_right[WIDTH-1])
                          : (w_left[WIDTH-1] == w_right[WIDTH-1]));
      w_ovf   = r_a_sign ? w_sovf : w_carry;
      // On signed overflow the true result has the sign of the left operand.
      if (r_a_sign) begin
         w_sat_val = w_left[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
         w_sat_val = w_is_sub ? '0 : '1;
      end
      w_z = ((SATURATE != 0) && w_ovf) ? w_sat_val : w_sum[WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_valid <= 1'b0;
         r_a_op    <= '0;
         r_a_sign  <= 1'b0;
         r_a_x     <= '0;
         r_a_y     <= '0;
      end else begin
         if (w_a_ready) begin
            r_a_valid <= in_valid;
         end
         if (w_in_xfer) begin
            r_a_op   <= op;
            r_a_sign <= sign;
            r_a_x    <= x;
            r_a_y    <= y;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_b_valid <= 1'b0;
         r_z       <= '0;
         r_carry   <= 1'b0;
         r_ovf     <= 1'b0;
         r_zero    <= 1'b0;
      end else begin
         if (w_b_ready) begin
            r_b_valid <= r_a_valid;
         end
         if (w_a_xfer) begin
            r_z     <= w_z;
            r_carry <= w_carry;
            r_ovf   <= w_ovf;
            r_zero  <= (w_z == '0);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
      end else if (w_a_xfer && w_is_acc) begin
         r_acc <= w_z;
      end else if (acc_clr) begin
         r_acc <= '0;
      end
   end

   assign in_ready  = w_a_ready;
   assign out_valid = r_b_valid;
   assign z         = r_z;
   assign carry     = r_carry;
   assign ovf       = r_ovf;
   assign zero      = r_zero;

endmodule

// File: tb/tb_add_sub_pipe.sv
// Bench for add_sub_pipe: a wrapping and a saturating instance share one stimulus
// stream; results are scored against an integer-arithmetic reference model.
module tb_add_sub_pipe;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [1:0]   op;
  logic         sign;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         acc_clr;
  logic         out_ready;

  logic         in_ready0, in_ready1;
  logic         out_valid0, out_valid1;
  logic [W-1:0] z0, z1;
  logic         c0, c1, o0, o1, zr0, zr1;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_out = 0;
  bit chk_lat = 0;

  logic [W-1:0] macc0, macc1;
  logic [W+2:0] me0, me1;
  logic [W+2:0] exp_q0[$];
  logic [W+2:0] exp_q1[$];
  int           lat_q[$];
  int           lt;

  add_sub_pipe #(.WIDTH(W), .SATURATE(0)) d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .op(op), .sign(sign), .x(x), .y(y), .acc_clr(acc_clr),
    .out_valid(out_valid0), .out_ready(out_ready), .z(z0),
    .carry(c0), .ovf(o0), .zero(zr0));

  add_sub_pipe #(.WIDTH(W), .SATURATE(1)) d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .op(op), .sign(sign), .x(x), .y(y), .acc_clr(acc_clr),
    .out_valid(out_valid1), .out_ready(out_ready), .z(z1),
    .carry(c1), .ovf(o1), .zero(zr1));

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: evaluate the true mathematical result, then classify by range.
  function automatic logic [W+2:0] model(input logic [1:0] mop, input logic sg,
                                         input logic [W-1:0] xv, input logic [W-1:0] yv,
                                         input logic [W-1:0] accv, input logic clr, input bit sat);
    logic [W-1:0] lv, rv, zw;
    int tu, ts, zz;
    bit cy, ov;
    lv = mop[1] ? (clr ? '0 : accv) : xv;
    rv = mop[1] ? xv : yv;
    tu = mop[0] ? (int'(lv) - int'(rv)) : (int'(lv) + int'(rv));
    ts = mop[0] ? (int'($signed(lv)) - int'($signed(rv))) : (int'($signed(lv)) + int'($signed(rv)));
    cy = (tu < 0) || (tu > (1 << W) - 1);
    ov = sg ? ((ts < -(1 << (W-1))) || (ts > (1 << (W-1)) - 1)) : cy;
    zz = tu;
    if (sat && ov) begin
      if (sg) zz = (ts > 0) ? (1 << (W-1)) - 1 : -(1 << (W-1));
      else    zz = (tu < 0) ? 0 : (1 << W) - 1;
    end
    zw = zz[W-1:0];
    return {zw, cy, ov, (zw == '0)};
  endfunction

  // scoreboard: model at input acceptance, compare at output acceptance
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready0) begin
        me0 = model(op, sign, x, y, macc0, acc_clr, 1'b0);
        me1 = model(op, sign, x, y, macc1, acc_clr, 1'b1);
        exp_q0.push_back(me0);
        exp_q1.push_back(me1);
        lat_q.push_back(cyc);
        if (op[1]) begin
          macc0 = me0[W+2:3];
          macc1 = me1[W+2:3];
        end
      end
      if (out_valid0 && out_ready) begin
        check("sb0_nonempty", 32'(exp_q0.size() != 0), 1);
        if (exp_q0.size() != 0) begin
          me0 = exp_q0.pop_front();
          check("sb0_z", 32'(z0), 32'(me0[W+2:3]));
          check("sb0_carry", 32'(c0), 32'(me0[2]));
          check("sb0_ovf", 32'(o0), 32'(me0[1]));
          check("sb0_zero", 32'(zr0), 32'(me0[0]));
        end
        if (lat_q.size() != 0) begin
          lt = lat_q.pop_front();
          if (chk_lat) check("latency", 32'(cyc - lt), 2);
        end
        n_out++;
      end
      if (out_valid1 && out_ready) begin
        check("sb1_nonempty", 32'(exp_q1.size() != 0), 1);
        if (exp_q1.size() != 0) begin
          me1 = exp_q1.pop_front();
          check("sb1_z", 32'(z1), 32'(me1[W+2:3]));
          check("sb1_carry", 32'(c1), 32'(me1[2]));
          check("sb1_ovf", 32'(o1), 32'(me1[1]));
          check("sb1_zero", 32'(zr1), 32'(me1[0]));
        end
      end
    end
  end

  // driver: starts and ends just after a rising edge
  task automatic send(input logic [1:0] o, input logic s, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic clr, output int stalls);
    bit got;
    got = 0;
    stalls = 0;
    op = o; sign = s; x = a; y = b; acc_clr = clr; in_valid = 1'b1;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = in_ready0;
      if (!got) stalls++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("send_accept", 32'(got), 1);
    if (clr) begin
      @(posedge clk); #1;
      acc_clr = 1'b0;
    end
  endtask

  task automatic expect_out(input string tag, input logic [W-1:0] ez0, input logic [W-1:0] ez1,
                            input logic ec, input logic eo, input logic ezr0, input logic ezr1);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid0 && n < 10) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_valid"}, 32'(out_valid0 && out_valid1), 1);
    check({tag, "_z_wrap"}, 32'(z0), 32'(ez0));
    check({tag, "_z_sat"}, 32'(z1), 32'(ez1));
    check({tag, "_carry"}, 32'({c0, c1}), 32'({ec, ec}));
    check({tag, "_ovf"}, 32'({o0, o1}), 32'({eo, eo}));
    check({tag, "_zero"}, 32'({zr0, zr1}), 32'({ezr0, ezr1}));
    @(posedge clk); #1;
  endtask

  initial begin
    int st;
    int base;
    bit acc_flag;
    rst_n = 1'b0; in_valid = 1'b0; op = '0; sign = 1'b0; x = '0; y = '0;
    acc_clr = 1'b0; out_ready = 1'b1;
    macc0 = '0; macc1 = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'({out_valid0, out_valid1}), 0);
    check("rst_z", 32'({z0, z1}), 0);
    check("rst_flags", 32'({c0, o0, zr0, c1, o1, zr1}), 0);
    check("rst_in_ready", 32'({in_ready0, in_ready1}), 32'b11);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed arithmetic corners
    send(2'b00, 1'b0, 8'd200, 8'd100, 1'b0, st);
    expect_out("add_uovf", 8'd44, 8'd255, 1'b1, 1'b1, 1'b0, 1'b0);
    send(2'b01, 1'b1, 8'h80, 8'h01, 1'b0, st);
    expect_out("sub_sovf", 8'h7F, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
    send(2'b01, 1'b1, 8'd5, 8'd5, 1'b0, st);
    expect_out("sub_zero", 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);

    // accumulate, clear-with-op, saturating acc_sub
    send(2'b10, 1'b0, 8'd10, 8'd99, 1'b0, st);
    expect_out("acc10", 8'd10, 8'd10, 1'b0, 1'b0, 1'b0, 1'b0);
    send(2'b10, 1'b0, 8'd20, 8'd0, 1'b0, st);
    expect_out("acc30", 8'd30, 8'd30, 1'b0, 1'b0, 1'b0, 1'b0);
    send(2'b10, 1'b0, 8'd30, 8'd0, 1'b0, st);
    expect_out("acc60", 8'd60, 8'd60, 1'b0, 1'b0, 1'b0, 1'b0);
    send(2'b10, 1'b0, 8'd5, 8'd0, 1'b1, st);
    expect_out("acc_clr5", 8'd5, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    send(2'b11, 1'b0, 8'd7, 8'd0, 1'b0, st);
    expect_out("acc_sub7", 8'hFE, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1);

    // throughput and latency
    chk_lat = 1;
    for (int i = 1; i <= 4; i++) begin
      send(2'b00, 1'b0, W'(i), W'(i), 1'b0, st);
      check("tput_no_stall", 32'(st), 0);
    end
    repeat (4) @(posedge clk);
    #1;
    chk_lat = 0;

    // backpressure: out_ready low for 4 cycles
    base = n_out;
    out_ready = 1'b0;
    op = 2'b00; sign = 1'b0; y = '0; x = 8'd10; in_valid = 1'b1;
    @(negedge clk);
    check("bp_accept1", 32'(in_ready0), 1);
    @(posedge clk); #1;
    x = 8'd20;
    @(negedge clk);
    check("bp_accept2", 32'(in_ready0), 1);
    @(posedge clk); #1;
    x = 8'd30;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("bp_in_ready_low", 32'({in_ready0, in_ready1}), 0);
      check("bp_z_hold", 32'({z0, z1}), 32'({8'd10, 8'd10}));
      check("bp_out_valid", 32'({out_valid0, out_valid1}), 32'b11);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(2'b00, 1'b0, 8'd30, 8'd0, 1'b0, st);
    send(2'b00, 1'b0, 8'd40, 8'd0, 1'b0, st);
    repeat (5) @(posedge clk);
    #1;
    check("bp_out_count", 32'(n_out - base), 4);

    // randomized stream with random gaps and backpressure
    acc_flag = 0;
    in_valid = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!in_valid || acc_flag) begin
        in_valid = ($urandom_range(0, 3) != 0);
        op = 2'($urandom_range(0, 3));
        sign = 1'($urandom_range(0, 1));
        x = W'($urandom);
        y = W'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc_flag = in_valid && in_ready0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rand_drained0", 32'(exp_q0.size()), 0);
    check("rand_drained1", 32'(exp_q1.size()), 0);

    // asynchronous reset with two beats in flight
    send(2'b10, 1'b0, 8'd50, 8'd0, 1'b0, st);
    send(2'b10, 1'b0, 8'd60, 8'd0, 1'b0, st);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'({out_valid0, out_valid1}), 0);
    check("mid_rst_z", 32'({z0, z1}), 0);
    check("mid_rst_flags", 32'({c0, o0, zr0, c1, o1, zr1}), 0);
    exp_q0.delete();
    exp_q1.delete();
    lat_q.delete();
    macc0 = '0;
    macc1 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_no_stale", 32'({out_valid0, out_valid1}), 0);
    end
    @(posedge clk); #1;
    send(2'b10, 1'b0, 8'd3, 8'd0, 1'b0, st);
    expect_out("post_rst_acc3", 8'd3, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/add_sub_pipe.md
Name: add_sub_pipe

Overview:
Parametrised, pipelined successor to the combinational add/sub unit. It performs add, subtract, accumulate-add and accumulate-subtract on WIDTH-bit operands, with optional saturation and signed/unsigned overflow detection. Results carry carry, overflow and zero flags. The block has a two-stage valid/ready pipeline and sits between an operand source and the ALU result bus.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
SATURATE, 0, 1 = clamp result on overflow; 0 = wrap modulo 2^WIDTH

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept operand beat
op  input  2  00 add, 01 sub, 10 acc_add, 11 acc_sub
sign  input  1  1 = signed (two's complement) overflow/saturation, 0 = unsigned
x  input  WIDTH  operand A (accumulate ops: value added to/subtracted from acc)
y  input  WIDTH  operand B (ignored for accumulate ops)
acc_clr  input  1  synchronous accumulator clear, sampled every cycle
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
z  output  WIDTH  result
carry  output  1  unsigned carry-out (add) / borrow (sub), pre-saturation
ovf  output  1  overflow per sign mode
zero  output  1  z == 0 (post-saturation)

Behaviour:
- Reset (rst_n low, async): stage A/B valids=0, out_valid=0, z=0, carry=0, ovf=0, zero=0, acc=0. Any in-flight beats are dropped, not emitted after reset release.
- Handshake: transfer on valid&&ready at each boundary. While asserted, valid and payload are held until accepted; the block never drops or duplicates beats.
- Stage A registers {op, sign, x, y}. Stage B computes the result and registers {z, flags}.
- b_ready = !b_valid || out_ready. a_ready = !a_valid || b_ready. in_ready = a_ready.
- Latency: 2 cycles from input transfer to out_valid when unstalled. Throughput is 1 beat/cycle with out_ready held high.
- Arithmetic is done at WIDTH+1 bits.
  - add: r = x + y, carry = r[WIDTH].
  - sub: r = x - y, carry = borrow (x < y unsigned).
  - acc ops: left operand = acc, right operand = x.
- ovf:
  - sign=0: ovf = carry.
  - sign=1 add: ovf = operands share MSB and result MSB differs.
  - sign=1 sub: ovf = operand MSBs differ and result MSB differs from left operand MSB.
- Saturation (SATURATE=1, ovf=1):
  - unsigned add -> all-ones; unsigned sub -> 0.
  - signed -> 0x7F.. if true result is positive, 0x80.. if negative.
  - SATURATE=0: z = r[WIDTH-1:0].
- Accumulator:
  - acc updates only when an acc op moves from stage A into stage B: acc <= z (post-saturation).
  - z for an acc op equals the new acc value. Non-acc ops never touch acc.
- acc_clr:
  - If asserted in a cycle with no acc-op transfer: acc <= 0 at that edge.
  - If asserted in the same cycle an acc op transfers A->B: clear takes priority, left operand is treated as 0, and acc <= 0 ± x (saturated).
- Flags and z are registered with the result and are valid only when out_valid=1. They hold while a stall is in progress.
- acc_clr and op changes never disturb beats already in stage B.

Test Plan:
- WIDTH=8, sign=0, add x=200 y=100: SATURATE=1 -> z=255, carry=1, ovf=1, zero=0; SATURATE=0 -> z=44, carry=1, ovf=1.
- sign=1, sub x=0x80 y=0x01: ovf=1, carry=0. SATURATE=1 -> z=0x80; SATURATE=0 -> z=0x7F. Also sub x=5 y=5 -> z=0, zero=1.
- Throughput/latency: 4 back-to-back adds (1+1, 2+2, 3+3, 4+4) with out_ready=1. Outputs 2,4,6,8 appear on consecutive cycles; the first appears 2 cycles after its input transfer; in_ready stays 1.
- Backpressure: out_ready=0 for 4 cycles while in_valid=1. in_ready drops after 2 beats are accepted; z holds stable; after release, all beats emerge in order, none lost or duplicated.
- Accumulate: acc_add x=10, 20, 30 -> z=10, 30, 60. Then acc_clr together with acc_add x=5 -> z=5. Then acc_sub x=7, sign=0, SATURATE=1 -> z=0, ovf=1.
- Reset: assert rst_n=0 mid-stream with 2 beats in flight. All outputs go to 0 immediately. After release, no stale out_valid appears and the next acc_add x=3 gives z=3.
